// File: rtl/dcache_port_arbiter.sv
// Shares the L1 data-cache request port between the memory stage (port C, priority)
// and an auxiliary requester (port A) with a starvation guard and nack retry.
module dcache_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req_valid,
  input  logic        c_req_we,
  input  logic [29:0] c_req_addr,
  input  logic [31:0] c_req_data,
  input  logic [3:0]  c_req_mask,
  output logic        c_resp_ack,
  output logic [31:0] c_resp_data,
  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic        a_req_we,
  input  logic [29:0] a_req_addr,
  input  logic [31:0] a_req_data,
  input  logic [3:0]  a_req_mask,
  output logic        a_resp_valid,
  output logic [31:0] a_resp_data,
  output logic        cache_req_valid,
  output logic        cache_req_we,
  output logic [29:0] cache_req_addr,
  output logic [31:0] cache_req_data,
  output logic [3:0]  cache_req_mask,
  input  logic        cache_resp_ack,
  input  logic [31:0] cache_resp_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, PEND, INFL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          own_c;
  logic          a_issue;
  logic          a_we_q;
  logic [29:0]   a_addr_q;
  logic [31:0]   a_data_q;
  logic [3:0]    a_mask_q;

  // Port A takes the cache when C is idle or when A has lost STARVE_LIMIT times in a row.
  assign a_issue = !rst && (state == PEND) && (!c_req_valid || (starve_cnt == LIMIT));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_req_valid) state_nxt = PEND;
      PEND:    if (a_issue)     state_nxt = INFL;
      INFL:    state_nxt = cache_resp_ack ? IDLE : PEND;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    a_req_ready  = 1'b0;
    a_resp_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    a_req_ready  = 1'b1;
        INFL:    a_resp_valid = cache_resp_ack;
        default: ;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; they are only consumed after a capture in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && a_req_valid) begin
      a_we_q   <= a_req_we;
      a_addr_q <= a_req_addr;
      a_data_q <= a_req_data;
      a_mask_q <= a_req_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == PEND && !a_issue) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Remembers whether the request sent this cycle belongs to port C.
  always_ff @(posedge clk) begin
    if (rst) own_c <= 1'b0;
    else     own_c <= c_req_valid && !a_issue;
  end

  assign cache_req_valid = !rst && (a_issue || c_req_valid);
  assign cache_req_we    = a_issue ? a_we_q   : c_req_we;
  assign cache_req_addr  = a_issue ? a_addr_q : c_req_addr;
  assign cache_req_data  = a_issue ? a_data_q : c_req_data;
  assign cache_req_mask  = a_issue ? a_mask_q : c_req_mask;

  assign c_resp_ack  = !rst && own_c && cache_resp_ack;
  assign c_resp_data = cache_resp_data;
  assign a_resp_data = cache_resp_data;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed vector table, corner sequences,
// and randomized traffic against a request-level reference model.
module tb_dcache_port_arbiter;

  localparam int LIMIT = 8;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } areq_t;

  typedef struct packed {
    logic        rst;
    logic        c_v;
    areq_t       c_in;
    logic        a_v;
    areq_t       a_in;
    logic        ack;
    logic [31:0] rdata;
    logic        e_ready;
    logic        e_cv;
    areq_t       e_req;
    logic        e_cack;
    logic        e_aresp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req_valid, c_req_we;
  logic [29:0] c_req_addr;
  logic [31:0] c_req_data;
  logic [3:0]  c_req_mask;
  logic        c_resp_ack;
  logic [31:0] c_resp_data;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [29:0] a_req_addr;
  logic [31:0] a_req_data;
  logic [3:0]  a_req_mask;
  logic        a_resp_valid;
  logic [31:0] a_resp_data;
  logic        cache_req_valid, cache_req_we;
  logic [29:0] cache_req_addr;
  logic [31:0] cache_req_data;
  logic [3:0]  cache_req_mask;
  logic        cache_resp_ack;
  logic [31:0] cache_resp_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_we(c_req_we), .c_req_addr(c_req_addr),
    .c_req_data(c_req_data), .c_req_mask(c_req_mask),
    .c_resp_ack(c_resp_ack), .c_resp_data(c_resp_data),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_data(a_req_data), .a_req_mask(a_req_mask),
    .a_resp_valid(a_resp_valid), .a_resp_data(a_resp_data),
    .cache_req_valid(cache_req_valid), .cache_req_we(cache_req_we),
    .cache_req_addr(cache_req_addr), .cache_req_data(cache_req_data),
    .cache_req_mask(cache_req_mask),
    .cache_resp_ack(cache_resp_ack), .cache_resp_data(cache_resp_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic cv, input areq_t c, input logic av,
                       input areq_t a, input logic ack, input logic [31:0] rd);
    rst             = r;
    c_req_valid     = cv;
    c_req_we        = c.we;
    c_req_addr      = c.addr;
    c_req_data      = c.data;
    c_req_mask      = c.mask;
    a_req_valid     = av;
    a_req_we        = a.we;
    a_req_addr      = a.addr;
    a_req_data      = a.data;
    a_req_mask      = a.mask;
    cache_resp_ack  = ack;
    cache_resp_data = rd;
  endtask

  // Compares all visible outputs for the current cycle; payload only where it is meaningful.
  task automatic check_cycle(input string tag, input logic e_ready, input logic e_cv,
                             input areq_t e_req, input logic e_cack, input logic e_aresp);
    check({tag, " a_req_ready"},     32'(a_req_ready),     32'(e_ready));
    check({tag, " cache_req_valid"}, 32'(cache_req_valid), 32'(e_cv));
    check({tag, " c_resp_ack"},      32'(c_resp_ack),      32'(e_cack));
    check({tag, " a_resp_valid"},    32'(a_resp_valid),    32'(e_aresp));
    if (e_cv) begin
      check({tag, " cache_req_we"},   32'(cache_req_we),   32'(e_req.we));
      check({tag, " cache_req_addr"}, 32'(cache_req_addr), 32'(e_req.addr));
      check({tag, " cache_req_data"}, cache_req_data,      e_req.data);
      check({tag, " cache_req_mask"}, 32'(cache_req_mask), 32'(e_req.mask));
    end
    if (e_cack)  check({tag, " c_resp_data"}, c_resp_data, cache_resp_data);
    if (e_aresp) check({tag, " a_resp_data"}, a_resp_data, cache_resp_data);
  endtask

  vec_t  tbl [8];
  areq_t no_req, c10, a20, a40, a33, c200, a77, c_r;

  // Reference model state: request-level view of port A and of the last cache owner.
  logic  m_busy, m_sent, m_c_sent;
  int    m_losses;
  areq_t m_req;

  initial begin
    no_req = '0;
    c10    = '{1'b0, 30'h10, 32'h0, 4'hF};
    a20    = '{1'b1, 30'h20, 32'h1234_5678, 4'h3};
    a40    = '{1'b1, 30'h40, 32'h0000_55AA, 4'hF};
    a33    = '{1'b1, 30'h33, 32'hCAFE_F00D, 4'h5};
    c200   = '{1'b0, 30'h200, 32'h0, 4'hF};
    a77    = '{1'b0, 30'h77, 32'h0, 4'hF};

    //           rst   c_v   c_in  a_v   a_in    ack   rdata          ready cv    req     cack  aresp
    tbl[0] = '{1'b1, 1'b1, c10,  1'b0, no_req, 1'b0, 32'h0,         1'b0, 1'b0, no_req, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, no_req, 1'b0, no_req, 1'b0, 32'h0,       1'b1, 1'b0, no_req, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, c10,  1'b0, no_req, 1'b0, 32'h0,         1'b1, 1'b1, c10,    1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, no_req, 1'b0, no_req, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, no_req, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, no_req, 1'b1, a20, 1'b0, 32'h0,          1'b1, 1'b0, no_req, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, no_req, 1'b0, no_req, 1'b0, 32'h0,       1'b0, 1'b1, a20,    1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, no_req, 1'b0, no_req, 1'b1, 32'hA5A5_0F0F, 1'b0, 1'b0, no_req, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, no_req, 1'b0, no_req, 1'b0, 32'h0,       1'b1, 1'b0, no_req, 1'b0, 1'b0};

    drive(1'b1, 1'b0, no_req, 1'b0, no_req, 1'b0, 32'h0);
    tick();

    // Reset, C-only load, A-only store.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rst, tbl[i].c_v, tbl[i].c_in, tbl[i].a_v, tbl[i].a_in, tbl[i].ack, tbl[i].rdata);
      @(negedge clk);
      check_cycle($sformatf("tbl%0d", i), tbl[i].e_ready, tbl[i].e_cv, tbl[i].e_req,
                  tbl[i].e_cack, tbl[i].e_aresp);
      tick();
    end

    // Starvation: C requests every cycle, A accepted at k=0 and forced through at k=1+LIMIT.
    for (int k = 0; k < 12; k++) begin
      c_r = '{1'b0, 30'(32'h100 + k), 32'h0, 4'hF};
      drive(1'b0, 1'b1, c_r, k == 0, a40, 1'b1, 32'h1000 + 32'(k));
      @(negedge clk);
      check_cycle($sformatf("starve%0d", k), (k == 0) || (k == 11), 1'b1,
                  (k == 1 + LIMIT) ? a40 : c_r, (k >= 1) && (k != 2 + LIMIT), k == 2 + LIMIT);
      tick();
    end

    // Nack retry: first issue nacked, C wins k=3, A reissues identically at k=4, ack at k=5.
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, k == 3, c200, k == 0, a33, (k == 4) || (k == 5), 32'h7700 + 32'(k));
      @(negedge clk);
      check_cycle($sformatf("retry%0d", k), (k == 0) || (k == 6),
                  (k == 1) || (k == 3) || (k == 4), (k == 3) ? c200 : a33, k == 4, k == 5);
      tick();
    end

    // Reset while A is in flight: response is dropped, response after release is not routed.
    for (int k = 0; k < 4; k++) begin
      drive(k == 2, k == 2, c10, k == 0, a77, k >= 2, 32'hBEEF_0000 + 32'(k));
      @(negedge clk);
      check_cycle($sformatf("rstinfl%0d", k), (k == 0) || (k == 3), k == 1, a77, 1'b0, 1'b0);
      tick();
    end
    // Starvation counter restarted from zero after reset: A forced through exactly LIMIT+1 later.
    for (int k = 0; k < 10; k++) begin
      c_r = '{1'b0, 30'(32'h300 + k), 32'h0, 4'hF};
      drive(1'b0, 1'b1, c_r, k == 0, a40, 1'b0, 32'h0);
      @(negedge clk);
      check_cycle($sformatf("poststarve%0d", k), k == 0, 1'b1,
                  (k == 1 + LIMIT) ? a40 : c_r, 1'b0, 1'b0);
      tick();
    end

    // Randomized traffic against the reference model.
    drive(1'b1, 1'b0, no_req, 1'b0, no_req, 1'b0, 32'h0);
    tick();
    m_busy = 1'b0; m_sent = 1'b0; m_c_sent = 1'b0; m_losses = 0; m_req = '0;
    for (int n = 0; n < 3000; n++) begin
      logic  e_ready, e_cv, e_cack, e_aresp, a_try, a_go, took;
      areq_t rc, ra;
      rc = '{1'($urandom), 30'($urandom), $urandom, 4'($urandom)};
      ra = '{1'($urandom), 30'($urandom), $urandom, 4'($urandom)};
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, rc,
            1'($urandom), ra, $urandom_range(0, 4) != 0, $urandom);
      @(negedge clk);
      if (rst) begin
        e_ready = 1'b0; e_cv = 1'b0; e_cack = 1'b0; e_aresp = 1'b0; a_try = 1'b0; a_go = 1'b0;
      end else begin
        a_try   = m_busy && !m_sent;
        a_go    = a_try && (!c_req_valid || m_losses >= LIMIT);
        e_ready = !m_busy;
        e_cv    = a_go || c_req_valid;
        e_cack  = m_c_sent && cache_resp_ack;
        e_aresp = m_sent && cache_resp_ack;
      end
      check_cycle($sformatf("rnd%0d", n), e_ready, e_cv, a_go ? m_req : rc, e_cack, e_aresp);
      if (rst) begin
        m_busy = 1'b0; m_sent = 1'b0; m_c_sent = 1'b0; m_losses = 0;
      end else begin
        took     = !m_busy && a_req_valid;
        m_c_sent = c_req_valid && !a_go;
        if (m_sent) begin
          m_sent   = 1'b0;
          m_losses = 0;
          if (cache_resp_ack) m_busy = 1'b0;
        end else if (a_go) begin
          m_sent   = 1'b1;
          m_losses = 0;
        end else if (a_try) begin
          m_losses++;
        end
        if (took) begin
          m_busy = 1'b1;
          m_req  = ra;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
